// File: rtl/md_sequencer_if.sv
// md_sequencer_if: E-stage mult/div issue bus plus HI/LO and stall results.
//   master drives start/op/flush/a/b/d_is_md; slave returns busy/md_stall/hi/lo.
interface md_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, flush, a, b, d_is_md, input busy, md_stall, hi, lo);
  modport slave  (input start, op, flush, a, b, d_is_md, output busy, md_stall, hi, lo);
endinterface

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mult/div occupancy model owning HI/LO, with D-stage stall request.
//   clk, reset (sync, active-high); bus.slave: start/op/flush/a/b/d_is_md in,
//   busy/md_stall/hi/lo out.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  md_sequencer_if.slave bus
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
  logic          accept;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   ua, ub, uq, ur, sq, sr, dq, dr;
  assign accept = bus.start & ~bus.flush & (state_q == IDLE);
  assign prod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
  assign prod_u = {32'b0, bus.a} * {32'b0, bus.b};
  // Signed divide via magnitudes: quotient truncates toward zero, remainder
  // follows the dividend, and 0x80000000 / -1 wraps to 0x80000000 naturally.
  always_comb begin
    ua = bus.a[31] ? -bus.a : bus.a;
    ub = bus.b[31] ? -bus.b : bus.b;
    uq = ub == 32'd0 ? 32'd0 : ua / ub;
    ur = ub == 32'd0 ? 32'd0 : ua % ub;
    sq = (bus.a[31] ^ bus.b[31]) ? -uq : uq;
    sr = bus.a[31] ? -ur : ur;
    dq = bus.b == 32'd0 ? 32'd0 : bus.a / bus.b;
    dr = bus.b == 32'd0 ? 32'd0 : bus.a % bus.b;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    if (state_q == RUN) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        hi_d    = phi_q;
        lo_d    = plo_q;
      end
    end else if (accept) begin
      case (bus.op)
        3'd0, 3'd1: begin
          state_d = RUN;
          cnt_d   = CW'(MULT_CYCLES);
          {phi_d, plo_d} = bus.op[0] ? prod_u : prod_s;
        end
        3'd2, 3'd3: begin
          state_d = RUN;
          cnt_d   = CW'(DIV_CYCLES);
          // Divide by zero commits the current HI/LO back, i.e. leaves them unchanged.
          phi_d = bus.b == 32'd0 ? hi_q : (bus.op[0] ? dr : sr);
          plo_d = bus.b == 32'd0 ? lo_q : (bus.op[0] ? dq : sq);
        end
        3'd4: hi_d = bus.a;
        3'd5: lo_d = bus.a;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end
  assign bus.busy     = state_q == RUN;
  assign bus.md_stall = bus.d_is_md & (bus.busy | (bus.start & ~bus.flush & ~bus.op[2]));
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule
